// File: rtl/add_seq.sv
// add_seq: multi-cycle adder/subtractor. Operands are latched on accept and
// summed CHUNK bits per clock, LSB slice first, through one CHUNK-bit slice
// adder and a carry register. Valid/ready handshakes on input and output.
// Optional feature: define ADD_SEQ_SAT_EN to add the 'sat' input, which
// clamps the result to the signed extreme on overflow.
module add_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef ADD_SEQ_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    // Keep the counter at least one bit wide when a single slice covers WIDTH
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;       // already inverted for subtraction
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
`ifdef ADD_SEQ_SAT_EN
    logic               r_sat;
    logic [WIDTH-1:0]   w_clamp;
`endif

    logic [CHUNK-1:0]   w_a_sl;
    logic [CHUNK-1:0]   w_b_sl;
    logic [CHUNK:0]     w_slice;
    logic               w_last;
    logic               w_cout;
    logic               w_ovf;
    logic               w_accept;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_cnt == CNT_W'(NCHUNK - 1));

    // Select the operand slice addressed by the chunk counter
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_a_sl = r_a[i*CHUNK +: CHUNK];
                w_b_sl = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    // Slice adder plus final-slice carry-out and overflow flags
    always_comb begin
        w_slice = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_carry};
        w_cout  = w_slice[CHUNK];
        // Carry into the MSB equals a^b^s at that bit; overflow is it XOR carry out
        w_ovf   = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_slice[CHUNK-1] ^ w_cout;
    end

`ifdef ADD_SEQ_SAT_EN
    // On overflow both effective MSBs are equal; a's MSB gives the direction
    always_comb begin
        w_clamp = {WIDTH{1'b1}} >> 1;
        if (r_a[WIDTH-1]) begin
            w_clamp = ~w_clamp;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Operand latch, slice-by-slice accumulation and result flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
`ifdef ADD_SEQ_SAT_EN
            r_sat   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_cnt   <= '0;
`ifdef ADD_SEQ_SAT_EN
            r_sat   <= sat;
`endif
        end else if (r_state == RUN) begin
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            for (int unsigned i = 0; i < NCHUNK; i++) begin
                if (r_cnt == CNT_W'(i)) begin
                    r_sum[i*CHUNK +: CHUNK] <= w_slice[CHUNK-1:0];
                end
            end
            if (w_last) begin
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
`ifdef ADD_SEQ_SAT_EN
                if (r_sat && w_ovf) begin
                    r_sum <= w_clamp;
                end
`endif
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_add_seq.sv
// Bench for add_seq: five width/chunk configurations run side by side, each
// with a directed vector table, backpressure and mid-operation reset
// sequences, and random operands scored against an arithmetic model.
module tb_add_seq;

    typedef struct {
        logic        sub;
        logic        cin;
        logic        sat;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    localparam int NCFG = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;
    int n_done = 0;

    function automatic int unsigned cfg_w(input int i);
        return (i == 4) ? 32 : 16;
    endfunction

    function automatic int unsigned cfg_c(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2:       return 8;
            3:       return 16;
            default: return 8;
        endcase
    endfunction

    function automatic vec_t mk(input logic s, input logic c, input logic st,
                                input logic [63:0] va, input logic [63:0] vb,
                                input logic [63:0] es, input logic ec, input logic eo);
        vec_t v;
        v.sub = s; v.cin = c; v.sat = st; v.a = va; v.b = vb;
        v.esum = es; v.ecout = ec; v.eovf = eo;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int unsigned W = cfg_w(g);
        localparam int unsigned C = cfg_c(g);
        localparam int unsigned N = W / C;
        localparam logic [63:0] ONES = (64'd1 << W) - 64'd1;
        localparam logic [63:0] MAXP = ONES >> 1;
        localparam logic [63:0] MINN = ONES ^ MAXP;

        logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
        logic [W-1:0] a, b, sum;
`ifdef ADD_SEQ_SAT_EN
        logic         sat;
`endif

        add_seq #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
`ifdef ADD_SEQ_SAT_EN
            .sat       (sat),
`endif
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout),
            .ovf       (ovf)
        );

        function automatic string nm(input string s);
            return $sformatf("W%0d/C%0d %s", W, C, s);
        endfunction

        // Plain-integer reference: unsigned sum for carry, signed sum for overflow
        function automatic void model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                      input logic fcin, input logic fsub, input logic fsat,
                                      output logic [W-1:0] fs, output logic fc,
                                      output logic fo);
            longint mod = longint'(1) << W;
            longint ua  = longint'(fa);
            longint ub  = longint'(fb);
            longint sa  = fa[W-1] ? ua - mod : ua;
            longint sb  = fb[W-1] ? ub - mod : ub;
            longint t, ts;
            logic [63:0] tt;
            if (fsub) begin
                t  = ua - ub;
                ts = sa - sb;
                fc = (ua >= ub);
            end else begin
                t  = ua + ub + longint'(fcin);
                ts = sa + sb + longint'(fcin);
                fc = (t >= mod);
            end
            tt = t;
            fs = tt[W-1:0];
            fo = (ts > mod / 2 - 1) || (ts < -(mod / 2));
            if (fsat && fo) begin
                tt = (ts > 0) ? MAXP : MINN;
                fs = tt[W-1:0];
            end
        endfunction

        task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                              input logic ocin, input logic osub, input logic osat,
                              output logic [W-1:0] rs, output logic rc, output logic ro,
                              output int lat);
            @(negedge clk);
            check(nm("ready before accept"), 64'(in_ready), 64'd1);
            in_valid = 1'b1; a = oa; b = ob; cin = ocin; sub = osub;
`ifdef ADD_SEQ_SAT_EN
            sat = osat;
`endif
            @(negedge clk);
            // Scramble inputs after the accept edge; they must not matter
            in_valid = 1'b0; a = W'($urandom()); b = W'($urandom());
            cin = 1'($urandom()); sub = 1'($urandom());
`ifdef ADD_SEQ_SAT_EN
            sat = ~osat;
`endif
            lat = 0;
            while (!out_valid && lat < 4 * N + 8) begin
                @(negedge clk);
                lat++;
            end
            rs = sum; rc = cout; ro = ovf;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check(nm("ready after handshake"), 64'(in_ready), 64'd1);
            check(nm("valid after handshake"), 64'(out_valid), 64'd0);
        endtask

        initial begin
            vec_t         tbl[$];
            logic [W-1:0] rs, es;
            logic         rc, ro, ec, eo;
            int           lat;

            tbl.push_back(mk(1'b0, 1'b0, 1'b0, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0));
            tbl.push_back(mk(1'b0, 1'b0, 1'b0, 64'd3, 64'd1, 64'd4, 1'b0, 1'b0));
            tbl.push_back(mk(1'b0, 1'b0, 1'b0, ONES, 64'd1, 64'd0, 1'b1, 1'b0));
            tbl.push_back(mk(1'b0, 1'b0, 1'b0, ONES - 1, ONES - 1, ONES - 3, 1'b1, 1'b0));
            tbl.push_back(mk(1'b0, 1'b0, 1'b0, MAXP, 64'd1, MINN, 1'b0, 1'b1));
            tbl.push_back(mk(1'b1, 1'b1, 1'b0, 64'd5, 64'd7, ONES - 1, 1'b0, 1'b0));
            tbl.push_back(mk(1'b1, 1'b1, 1'b0, 64'd7, 64'd5, 64'd2, 1'b1, 1'b0));
            tbl.push_back(mk(1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd1, 1'b0, 1'b0));
            tbl.push_back(mk(1'b0, 1'b0, 1'b0, MINN, MINN, 64'd0, 1'b1, 1'b1));
            tbl.push_back(mk(1'b1, 1'b0, 1'b0, MINN, 64'd1, MAXP, 1'b1, 1'b1));
            tbl.push_back(mk(1'b0, 1'b1, 1'b0, ONES, ONES, ONES, 1'b1, 1'b0));
            tbl.push_back(mk(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0));
`ifdef ADD_SEQ_SAT_EN
            tbl.push_back(mk(1'b0, 1'b0, 1'b1, MAXP, 64'd1, MAXP, 1'b0, 1'b1));
            tbl.push_back(mk(1'b0, 1'b0, 1'b1, MINN, MINN, MINN, 1'b1, 1'b1));
            tbl.push_back(mk(1'b1, 1'b0, 1'b1, MINN, 64'd1, MINN, 1'b1, 1'b1));
            tbl.push_back(mk(1'b0, 1'b0, 1'b1, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0));
            sat = 1'b0;
`endif

            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
            a = '0; b = '0; cin = 1'b0; sub = 1'b0;
            #1;
            check(nm("reset in_ready"), 64'(in_ready), 64'd1);
            check(nm("reset out_valid"), 64'(out_valid), 64'd0);
            check(nm("reset sum"), 64'(sum), 64'd0);
            check(nm("reset cout"), 64'(cout), 64'd0);
            check(nm("reset ovf"), 64'(ovf), 64'd0);
            @(negedge clk);
            rst = 1'b0;

            // Directed vectors
            for (int i = 0; i < tbl.size(); i++) begin
                vec_t v;
                v = tbl[i];
                run_op(v.a[W-1:0], v.b[W-1:0], v.cin, v.sub, v.sat, rs, rc, ro, lat);
                check(nm($sformatf("vec%0d sum", i)), 64'(rs), v.esum & ONES);
                check(nm($sformatf("vec%0d cout", i)), 64'(rc), 64'(v.ecout));
                check(nm($sformatf("vec%0d ovf", i)), 64'(ro), 64'(v.eovf));
                check(nm($sformatf("vec%0d latency", i)), 64'(lat), 64'(N));
            end

            // Backpressure: result held while out_ready stays low
            @(negedge clk);
            in_valid = 1'b1; a = W'(3); b = W'(4); cin = 1'b0; sub = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 4 * N + 8) begin
                @(negedge clk);
                lat++;
            end
            check(nm("bp latency"), 64'(lat), 64'(N));
            for (int i = 0; i < 5; i++) begin
                a = W'($urandom()); b = W'($urandom()); in_valid = ~in_valid;
                @(negedge clk);
                check(nm($sformatf("bp%0d sum", i)), 64'(sum), 64'd7);
                check(nm($sformatf("bp%0d out_valid", i)), 64'(out_valid), 64'd1);
                check(nm($sformatf("bp%0d in_ready", i)), 64'(in_ready), 64'd0);
            end
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b0;
            check(nm("bp release out_valid"), 64'(out_valid), 64'd0);
            check(nm("bp no accept on handshake"), 64'(in_ready), 64'd1);

            // Reset in the middle of an operation
            @(negedge clk);
            in_valid = 1'b1; a = W'(ONES); b = W'(ONES); cin = 1'b1; sub = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
            #1;
            check(nm("midrst sum"), 64'(sum), 64'd0);
            check(nm("midrst cout"), 64'(cout), 64'd0);
            check(nm("midrst ovf"), 64'(ovf), 64'd0);
            check(nm("midrst in_ready"), 64'(in_ready), 64'd1);
            check(nm("midrst out_valid"), 64'(out_valid), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            run_op(W'(16'h1234), W'(16'h1111), 1'b0, 1'b0, 1'b0, rs, rc, ro, lat);
            check(nm("post-rst sum"), 64'(rs), 64'h2345);
            check(nm("post-rst cout"), 64'(rc), 64'd0);
            check(nm("post-rst latency"), 64'(lat), 64'(N));

            // Random operands against the arithmetic model
            for (int i = 0; i < 1000; i++) begin
                logic [W-1:0] ra, rb;
                logic         rcin, rsub, rsat;
                logic [63:0]  pick;
                ra = W'($urandom()); rb = W'($urandom());
                if ($urandom_range(0, 7) == 0) begin
                    pick = ($urandom_range(0, 1) == 0) ? MAXP : MINN;
                    ra = pick[W-1:0];
                end
                if ($urandom_range(0, 7) == 0) begin
                    pick = ($urandom_range(0, 1) == 0) ? ONES : 64'd1;
                    rb = pick[W-1:0];
                end
                rcin = 1'($urandom()); rsub = 1'($urandom());
`ifdef ADD_SEQ_SAT_EN
                rsat = 1'($urandom());
`else
                rsat = 1'b0;
`endif
                model(ra, rb, rcin, rsub, rsat, es, ec, eo);
                run_op(ra, rb, rcin, rsub, rsat, rs, rc, ro, lat);
                check(nm($sformatf("rnd%0d sum a=%0h b=%0h sub=%0d", i, ra, rb, rsub)),
                      64'(rs), 64'(es));
                check(nm($sformatf("rnd%0d cout", i)), 64'(rc), 64'(ec));
                check(nm($sformatf("rnd%0d ovf", i)), 64'(ro), 64'(eo));
                check(nm($sformatf("rnd%0d latency", i)), 64'(lat), 64'(N));
            end

            n_done++;
        end
    end

    initial begin
        wait (n_done == NCFG);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #800000;
        n_run++;
        n_fail++;
        $display("FAIL timeout: %0d of %0d configurations finished", n_done, NCFG);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
